bit_select_stage: RTL

Registered, ready/valid bit-select stage that sits directly upstream of the fixed-wiring consumer modules in our array-select flow. Each output bit copies one input bit chosen by a runtime-programmable select map, so repeated and permuted bits come from registers instead of hard-wired concatenations. A 2-entry skid buffer decouples upstream from downstream backpressure at full throughput. The `O` bus drives the consumer's `I` port directly.

---
 rtl/bit_select_stage.sv | 100 ++++++++++
 1 files changed

// File: rtl/bit_select_stage.sv
// Registered ready/valid stage that remaps input bits through a programmable
// select map and buffers up to two beats in a skid buffer.
module bit_select_stage #(
  parameter int WIDTH = 4,
  parameter int SELW  = $clog2(WIDTH)
) (
  input  logic                    CLK,
  input  logic                    ASYNCRESETN,
  input  logic [WIDTH-1:0]        I,
  input  logic                    I_valid,
  output logic                    I_ready,
  output logic [WIDTH-1:0]        O,
  output logic                    O_valid,
  input  logic                    O_ready,
  input  logic [WIDTH*SELW-1:0]   cfg_sel,
  input  logic                    cfg_we,
  output logic [WIDTH*SELW-1:0]   map
);

  // state | meaning
  // EMPTY | no beat stored, O invalid
  // ONE   | head holds a beat
  // FULL  | head and skid both hold beats, upstream stalled
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam int MW = WIDTH * SELW;

  state_t           state;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic [MW-1:0]    map_q;
  logic [WIDTH-1:0] sel_data;
  logic             push;
  logic             pop;

  function automatic logic [MW-1:0] ident_map();
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[SELW*i +: SELW] = SELW'(i);
    return r;
  endfunction

  // Indices at or above WIDTH match no source bit and so leave the output bit 0.
  function automatic logic [WIDTH-1:0] sel_bits(input logic [WIDTH-1:0] d,
                                                input logic [MW-1:0]    m);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (int'(m[SELW*i +: SELW]) == j) r[i] = d[j];
      end
    end
    return r;
  endfunction

  assign sel_data = sel_bits(I, map_q);
  assign I_ready  = (state != FULL);
  assign O_valid  = (state != EMPTY);
  assign O        = head_q;
  assign map      = map_q;
  assign push     = I_valid & I_ready;
  assign pop      = O_valid & O_ready;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state  <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
      map_q  <= ident_map();
    end else begin
      if (cfg_we) map_q <= cfg_sel;
      case (state)
        EMPTY: begin
          if (push) begin
            head_q <= sel_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_q <= sel_data;
          end else if (push) begin
            skid_q <= sel_data;
            state  <= FULL;
          end else if (pop) begin
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
